// File: rtl/adc_pkg.sv
// Shared ADC result definitions: widths, OSR-mode encodings and the FIFO entry layout.
package adc_pkg;

    localparam int ADC_RESULT_W = 16;
    localparam int OSR_MODE_W   = 3;
    localparam int ENTRY_W      = ADC_RESULT_W + OSR_MODE_W;

    localparam logic [OSR_MODE_W-1:0] OSR_BYPASS = 3'b000;
    localparam logic [OSR_MODE_W-1:0] OSR_4      = 3'b001;
    localparam logic [OSR_MODE_W-1:0] OSR_16     = 3'b010;
    localparam logic [OSR_MODE_W-1:0] OSR_64     = 3'b011;
    localparam logic [OSR_MODE_W-1:0] OSR_256    = 3'b100;

    typedef struct packed {
        logic [OSR_MODE_W-1:0]   mode;
        logic [ADC_RESULT_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/adc_sample_fifo_if.sv
// Valid/ready read stream carrying one tagged ADC sample from the FIFO head.
interface adc_sample_fifo_if;
    import adc_pkg::*;

    logic                    rd_valid;
    logic                    rd_ready;
    logic [ADC_RESULT_W-1:0] rd_data;
    logic [OSR_MODE_W-1:0]   rd_mode;

    modport master (output rd_valid, output rd_data, output rd_mode, input  rd_ready);
    modport slave  (input  rd_valid, input  rd_data, input  rd_mode, output rd_ready);

endinterface

// File: rtl/adc_fifo_mem.sv
// DEPTH x ENTRY_W flop array with one synchronous write port and one asynchronous read port.
module adc_fifo_mem
    import adc_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  fifo_entry_t       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output fifo_entry_t       rdata_o
);

    fifo_entry_t mem_q [DEPTH];

    // NOTE: storage is deliberately not reset; validity comes from the level counter,
    // so stale entries are never presented and the array stays plain enable flops.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/adc_sample_fifo.sv
// Captures strobed oversampler results with their OSR tag into a FIFO and streams them out,
// with level, sticky overflow and level-threshold interrupt status.
module adc_sample_fifo
    import adc_pkg::*;
#(
    parameter  int DEPTH    = 16,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int THRESH_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_strobe,
    input  logic [ADC_RESULT_W-1:0] sample_data,
    input  logic [OSR_MODE_W-1:0]   sample_mode,
    adc_sample_fifo_if.master       rd,
    output logic [THRESH_W-1:0]     level,
    input  logic [THRESH_W-1:0]     threshold,
    output logic                    irq,
    output logic                    overflow,
    input  logic                    overflow_clr,
    input  logic                    flush
);

    localparam logic [THRESH_W-1:0] LEVEL_FULL = THRESH_W'(DEPTH);
    localparam logic [THRESH_W-1:0] LEVEL_ONE  = THRESH_W'(1);
    localparam logic [ADDR_W-1:0]   PTR_ONE    = ADDR_W'(1);

    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [THRESH_W-1:0] level_q,  level_d;
    logic                irq_q,    irq_d;
    logic                ovf_q,    ovf_d;

    logic        full;
    logic        pop;
    logic        push;
    logic        drop;
    fifo_entry_t wr_entry;
    fifo_entry_t head;

    assign full     = (level_q == LEVEL_FULL);
    assign rd.rd_valid = (level_q != '0);
    assign pop      = rd.rd_valid & rd.rd_ready & ~flush;
    // A full FIFO still accepts a strobe when the head leaves in the same cycle.
    assign push     = sample_strobe & (~full | pop) & ~flush;
    assign drop     = sample_strobe & full & ~pop & ~flush;
    assign wr_entry = '{mode: sample_mode, data: sample_data};

    adc_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      level_d = level_q + LEVEL_ONE;
            else if (pop && !push) level_d = level_q - LEVEL_ONE;
        end

        // Set beats clear so a drop in the clearing cycle is never lost.
        if (drop)              ovf_d = 1'b1;
        else if (overflow_clr) ovf_d = 1'b0;

        irq_d = (threshold != '0) && (level_d >= threshold);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            irq_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            irq_q    <= irq_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rd.rd_data = rd.rd_valid ? head.data : '0;
    assign rd.rd_mode = rd.rd_valid ? head.mode : '0;
    assign level      = level_q;
    assign irq        = irq_q;
    assign overflow   = ovf_q;

endmodule
